// File: rtl/wb_arbiter_3.sv
// ---------------------------------------------------------------------------
// wb_arbiter_3
// Round-robin arbiter plus output holding register for the shared 3-way
// write-back path.
//
// Requesters: 0 = ALU result, 1 = memory load, 2 = PC link/immediate.
// The winner's data and destination are captured into a single holding
// register and offered downstream with a valid/ready handshake.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   req[2:0]         per-requester write-back request
//   din0..din2       requester data (DATA_W)
//   addr0..addr2     requester destination register (ADDR_W)
//   gnt[2:0]         one-hot grant (combinational)
//   mux_sel[1:0]     encoded grant, 00 when nothing is granted
//   wb_valid         holding register holds a word
//   wb_data          held data
//   wb_addr          held destination
//   wb_ready         consumer accepts the held word
// ---------------------------------------------------------------------------
module wb_arbiter_3 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic [1:0]        mux_sel,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        last_r;
    logic [1:0]        first_s;
    logic [1:0]        second_s;
    logic              load_en_s;
    logic [2:0]        gnt_s;
    logic [1:0]        sel_s;
    logic              any_gnt_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] addr_r;

    // Successor of a requester index in the 0 -> 1 -> 2 -> 0 ring.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            2'd2:    next_idx = 2'd0;
            default: next_idx = 2'd0;
        endcase
    endfunction

    // One-hot mask for a requester index; the unused code maps to no requester.
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Round-robin grant: search starts just after the last winner, last winner is tried last.
    always_comb begin
        gnt_s     = 3'b000;
        load_en_s = (state_r == ST_EMPTY) | wb_ready;
        first_s   = next_idx(last_r);
        second_s  = next_idx(first_s);
        // rst gates the grant so nothing is offered while the block is held in reset.
        if (rst || !load_en_s) begin
            gnt_s = 3'b000;
        end else if ((req & onehot(first_s)) != 3'b000) begin
            gnt_s = onehot(first_s);
        end else if ((req & onehot(second_s)) != 3'b000) begin
            gnt_s = onehot(second_s);
        end else if ((req & onehot(last_r)) != 3'b000) begin
            gnt_s = onehot(last_r);
        end else begin
            gnt_s = 3'b000;
        end
        any_gnt_s = |gnt_s;
    end

    // Encode the grant and steer the winner's data/address toward the holding register.
    always_comb begin
        sel_s      = 2'b00;
        sel_data_s = din0;
        sel_addr_s = addr0;
        case (gnt_s)
            3'b010: begin
                sel_s      = 2'b01;
                sel_data_s = din1;
                sel_addr_s = addr1;
            end
            3'b100: begin
                sel_s      = 2'b10;
                sel_data_s = din2;
                sel_addr_s = addr2;
            end
            default: begin
                sel_s      = 2'b00;
                sel_data_s = din0;
                sel_addr_s = addr0;
            end
        endcase
    end

    // Next-state logic: a grant always leaves the register full; an accept with no grant drains it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (any_gnt_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (any_gnt_s) begin
                    state_nxt_s = ST_FULL;
                end else if (wb_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding register and round-robin pointer; data/addr keep their value when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
            last_r <= 2'd2;
        end else if (any_gnt_s) begin
            data_r <= sel_data_s;
            addr_r <= sel_addr_s;
            last_r <= sel_s;
        end else begin
            data_r <= data_r;
            addr_r <= addr_r;
            last_r <= last_r;
        end
    end

    assign gnt      = gnt_s;
    assign mux_sel  = sel_s;
    assign wb_valid = (state_r == ST_FULL);
    assign wb_data  = data_r;
    assign wb_addr  = addr_r;

endmodule

// File: tb/tb_wb_arbiter_3.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_3
// Self-checking bench for wb_arbiter_3: a vector table, hand-written
// reset/back-pressure sequences, and a randomized run against a reference
// model that picks winners by walking the requester ring.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_3;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] din [3];
    logic [2:0]  addr [3];
    logic [2:0]  gnt;
    logic [1:0]  mux_sel;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_addr;
    logic        wb_ready;

    int checks;
    int failures;

    wb_arbiter_3 #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din0     (din[0]),
        .din1     (din[1]),
        .din2     (din[2]),
        .addr0    (addr[0]),
        .addr1    (addr[1]),
        .addr2    (addr[2]),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr),
        .wb_ready (wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic        rdy;
        logic [2:0]  exp_gnt;
        logic [1:0]  exp_sel;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [2:0]  exp_addr;
    } vec_t;

    vec_t vecs [12];

    // Reference model state
    int          m_last;
    logic        m_valid;
    logic [15:0] m_data;
    logic [2:0]  m_addr;
    logic [2:0]  pend;
    int          wait_cnt [3];

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 3'b000;
        wb_ready = 1'b0;
        din[0] = 16'h1111; din[1] = 16'h2222; din[2] = 16'h3333;
        addr[0] = 3'd1;    addr[1] = 3'd2;    addr[2] = 3'd3;

        // req, rdy, gnt, sel, valid-after, data-after, addr-after
        vecs[0]  = '{3'b111, 1'b1, 3'b001, 2'b00, 1'b1, 16'h1111, 3'd1};
        vecs[1]  = '{3'b111, 1'b1, 3'b010, 2'b01, 1'b1, 16'h2222, 3'd2};
        vecs[2]  = '{3'b111, 1'b1, 3'b100, 2'b10, 1'b1, 16'h3333, 3'd3};
        vecs[3]  = '{3'b111, 1'b1, 3'b001, 2'b00, 1'b1, 16'h1111, 3'd1};
        vecs[4]  = '{3'b000, 1'b1, 3'b000, 2'b00, 1'b0, 16'h1111, 3'd1};
        vecs[5]  = '{3'b000, 1'b0, 3'b000, 2'b00, 1'b0, 16'h1111, 3'd1};
        vecs[6]  = '{3'b100, 1'b0, 3'b100, 2'b10, 1'b1, 16'h3333, 3'd3};
        vecs[7]  = '{3'b011, 1'b0, 3'b000, 2'b00, 1'b1, 16'h3333, 3'd3};
        vecs[8]  = '{3'b011, 1'b1, 3'b001, 2'b00, 1'b1, 16'h1111, 3'd1};
        vecs[9]  = '{3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 16'h2222, 3'd2};
        vecs[10] = '{3'b101, 1'b1, 3'b100, 2'b10, 1'b1, 16'h3333, 3'd3};
        vecs[11] = '{3'b000, 1'b0, 3'b000, 2'b00, 1'b1, 16'h3333, 3'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_data", {16'd0, wb_data}, 32'd0);
        chk("reset_gnt", {29'd0, gnt}, 32'd0);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            req      = vecs[i].req;
            wb_ready = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d_gnt", i), {29'd0, gnt}, {29'd0, vecs[i].exp_gnt});
            chk($sformatf("vec%0d_sel", i), {30'd0, mux_sel}, {30'd0, vecs[i].exp_sel});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), {16'd0, wb_data}, {16'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_addr", i), {29'd0, wb_addr}, {29'd0, vecs[i].exp_addr});
        end

        // ---------------- async reset mid-cycle while FULL ----------------
        req = 3'b111;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rst_data", {16'd0, wb_data}, 32'd0);
        chk("async_rst_gnt", {29'd0, gnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        din[0]   = 16'h1234;
        wb_ready = 1'b1;
        #2;
        chk("post_rst_gnt", {29'd0, gnt}, 32'b001);
        chk("post_rst_sel", {30'd0, mux_sel}, 32'd0);
        @(posedge clk);
        #1;
        chk("load_1234", {16'd0, wb_data}, 32'h1234);

        // ---------------- back-pressure ----------------
        req      = 3'b101;
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("bp%0d_gnt", i), {29'd0, gnt}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_data", i), {16'd0, wb_data}, 32'h1234);
            chk($sformatf("bp%0d_valid", i), {31'd0, wb_valid}, 32'd1);
        end
        wb_ready = 1'b1;
        din[2]   = 16'hCAFE;
        addr[2]  = 3'd6;
        #2;
        chk("bp_release_gnt", {29'd0, gnt}, 32'b100);
        @(posedge clk);
        #1;
        chk("bp_release_data", {16'd0, wb_data}, 32'hCAFE);
        chk("bp_release_addr", {29'd0, wb_addr}, 32'd6);

        // ---------------- reset mid-transfer ----------------
        req      = 3'b000;
        wb_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midxfer_rst_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req = 3'b110;
        #2;
        chk("midxfer_regrant_gnt", {29'd0, gnt}, 32'b010);
        chk("midxfer_regrant_sel", {30'd0, mux_sel}, 32'd1);
        @(posedge clk);
        #1;
        chk("midxfer_regrant_data", {16'd0, wb_data}, 32'h2222);

        // ---------------- randomized run against reference model ----------------
        req      = 3'b000;
        wb_ready = 1'b0;
        do_reset();
        m_last  = 2;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_addr  = 3'd0;
        pend    = 3'b000;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            int          win;
            logic        opp;
            logic [2:0]  exp_gnt;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    din[i]  = 16'($urandom);
                    addr[i] = 3'($urandom);
                end
            end
            req      = pend;
            wb_ready = ($urandom_range(0, 3) != 0);

            opp = !m_valid || wb_ready;
            win = -1;
            if (opp) begin
                for (int k = 1; k <= 3; k++) begin
                    if (win < 0 && pend[(m_last + k) % 3]) win = (m_last + k) % 3;
                end
            end
            exp_gnt = (win < 0) ? 3'b000 : 3'(1 << win);

            #2;
            chk("rnd_gnt", {29'd0, gnt}, {29'd0, exp_gnt});
            chk("rnd_sel", {30'd0, mux_sel}, (win < 0) ? 32'd0 : 32'(win));
            chk("rnd_valid", {31'd0, wb_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("rnd_data", {16'd0, wb_data}, {16'd0, m_data});
                chk("rnd_addr", {29'd0, wb_addr}, {29'd0, m_addr});
            end
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && opp) begin
                    if (gnt[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        chk($sformatf("fair_req%0d", i), (wait_cnt[i] <= 2) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
            end

            @(posedge clk);
            if (win >= 0) begin
                m_data    = din[win];
                m_addr    = addr[win];
                m_valid   = 1'b1;
                m_last    = win;
                pend[win] = 1'b0;
            end else if (wb_ready) begin
                m_valid = 1'b0;
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
